// File: rtl/line_window_loader.sv
// line_window_loader
//   Buffers the four most recent raster lines in four circular line banks and,
//   after each line from the fourth onward, scans them into 4x4 windows. The
//   windows are built in two ping-pong register sets for a row-rotating mux.
//
//   Handshakes:
//     pix_valid/pix_ready: a pixel transfers on a rising edge where both are 1.
//       pix_ready depends only on the state, never on pix_valid.
//     win_valid/win_ack: the published window (set `switch`, rows rotated by
//       `mux_sel`, leftmost column `win_col`) is taken on an edge where both
//       are 1. If a new window is published on that same edge, win_valid
//       stays 1. An ack while win_valid is 0 is ignored.
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     pix_in, pix_valid   raster pixel stream in
//     pix_ready           high while a line is being written (state WR_LINE)
//     win_s0, win_s1      window sets; bank g, tap i at [(4*g+i)*DATA_W +: DATA_W]
//     switch              published set (0 = win_s0, 1 = win_s1)
//     mux_sel             bank holding the top (oldest) window row
//     win_valid, win_ack  window handshake
//     win_col             leftmost column of the published window
//     frame_done          one-cycle pulse after the last window of a frame
//     dbg_state           current FSM state (0 WR_LINE, 1 LOAD, 2 PUB)
module line_window_loader #(
  parameter int DATA_W = 15,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [16*DATA_W-1:0] win_s0,
  output logic [16*DATA_W-1:0] win_s1,
  output logic                 switch,
  output logic [1:0]           mux_sel,
  output logic                 win_valid,
  input  logic                 win_ack,
  output logic [CW-1:0]        win_col,
  output logic                 frame_done,
  output logic [1:0]           dbg_state
);

  localparam int LW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_BASE = CW'(IMG_W - 4);
  localparam logic [LW-1:0] LINES     = LW'(IMG_H);
  localparam logic [LW-1:0] MIN_LINES = LW'(3);

  typedef enum logic [1:0] {
    ST_WR_LINE = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PUB     = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  logic [DATA_W-1:0]   r_mem [4][IMG_W];
  logic [1:0]          r_wr_bank;
  logic [CW-1:0]       r_wr_col;
  logic [LW-1:0]       r_line_cnt;
  logic [CW-1:0]       r_ld_base;
  logic [1:0]          r_step;
  logic [16*DATA_W-1:0] r_set0, r_set1;
  logic                r_switch;
  logic [1:0]          r_mux_sel;
  logic                r_win_valid;
  logic [CW-1:0]       r_win_col;
  logic                r_frame_done;

  logic                w_line_end;
  logic                w_slot_free;
  logic                w_flip;
  logic [CW-1:0]       w_rd_col;
  logic [DATA_W-1:0]   w_rd [4];
  logic [16*DATA_W-1:0] w_fill_cur;
  logic [16*DATA_W-1:0] w_shifted;

  assign w_line_end  = pix_valid && (r_wr_col == LAST_COL);
  assign w_slot_free = !r_win_valid || win_ack;
  assign w_flip      = (r_state == ST_PUB) && w_slot_free;
  assign w_rd_col    = r_ld_base + CW'(r_step);
  // The fill set is always the one not currently published.
  assign w_fill_cur  = r_switch ? r_set0 : r_set1;

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      w_rd[g] = r_mem[g][w_rd_col];
    end
  end

  // tap0 <- tap1 <- tap2 <- tap3 <- newly read column, per bank.
  always_comb begin
    w_shifted = '0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 3; i++) begin
        w_shifted[(4*g+i)*DATA_W +: DATA_W] = w_fill_cur[(4*g+i+1)*DATA_W +: DATA_W];
      end
      w_shifted[(4*g+3)*DATA_W +: DATA_W] = w_rd[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WR_LINE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WR_LINE: if (w_line_end && (r_line_cnt >= MIN_LINES)) w_next_state = ST_LOAD;
      ST_LOAD:    if (r_step == 2'd3) w_next_state = ST_PUB;
      ST_PUB: begin
        if (w_slot_free) begin
          if (r_ld_base < LAST_BASE) w_next_state = ST_LOAD;
          else                       w_next_state = ST_WR_LINE;
        end
      end
      default:    w_next_state = ST_WR_LINE;
    endcase
  end

  // Line banks carry no reset; every bank is rewritten before it is scanned.
  always_ff @(posedge clk) begin
    if (r_state == ST_WR_LINE && pix_valid) r_mem[r_wr_bank][r_wr_col] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank    <= '0;
      r_wr_col     <= '0;
      r_line_cnt   <= '0;
      r_ld_base    <= '0;
      r_step       <= '0;
      r_set0       <= '0;
      r_set1       <= '0;
      r_switch     <= 1'b0;
      r_mux_sel    <= '0;
      r_win_valid  <= 1'b0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_WR_LINE: begin
          if (pix_valid) begin
            if (w_line_end) begin
              r_wr_col   <= '0;
              r_wr_bank  <= r_wr_bank + 2'd1;
              r_line_cnt <= r_line_cnt + LW'(1);
              r_ld_base  <= '0;
              r_step     <= '0;
            end else begin
              r_wr_col <= r_wr_col + CW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (r_switch) r_set0 <= w_shifted;
          else          r_set1 <= w_shifted;
          r_step <= r_step + 2'd1;
        end
        ST_PUB: begin
          if (w_slot_free) begin
            r_switch  <= ~r_switch;
            // wr_bank already advanced past line L, so it names line L-3's bank.
            r_mux_sel <= r_wr_bank;
            r_win_col <= r_ld_base;
            if (r_ld_base < LAST_BASE) begin
              r_ld_base <= r_ld_base + CW'(1);
            end else begin
              r_ld_base <= '0;
              if (r_line_cnt == LINES) begin
                r_frame_done <= 1'b1;
                r_line_cnt   <= '0;
                r_wr_bank    <= '0;
              end
            end
          end
        end
        default: ;
      endcase

      if (w_flip)       r_win_valid <= 1'b1;
      else if (win_ack) r_win_valid <= 1'b0;
    end
  end

  assign pix_ready  = (r_state == ST_WR_LINE);
  assign win_s0     = r_set0;
  assign win_s1     = r_set1;
  assign switch     = r_switch;
  assign mux_sel    = r_mux_sel;
  assign win_valid  = r_win_valid;
  assign win_col    = r_win_col;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_line_window_loader.sv
module tb_line_window_loader;

  localparam int DW = 15;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int CWB = 3;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [16*DW-1:0]  win_s0, win_s1;
  logic              switch;
  logic [1:0]        mux_sel;
  logic              win_valid;
  logic              win_ack;
  logic [CWB-1:0]    win_col;
  logic              frame_done;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_sw = 1'b0;
  logic [16*DW-1:0] exp_q[$];

  line_window_loader #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_s0(win_s0), .win_s1(win_s1), .switch(switch),
    .mux_sel(mux_sel), .win_valid(win_valid), .win_ack(win_ack),
    .win_col(win_col), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected window after line row L of a frame, leftmost column c.
  // Bank g holds the line k in L-3..L with k%4 == g; pixel = 16*k + col + off.
  function automatic logic [16*DW-1:0] exp_win(input int l, input int c, input int off);
    logic [16*DW-1:0] v;
    v = '0;
    for (int k = l - 3; k <= l; k++) begin
      for (int i = 0; i < 4; i++) begin
        v[(4*(k%4)+i)*DW +: DW] = DW'(16*k + c + i + off);
      end
    end
    return v;
  endfunction

  // driver: one full line; caller sits #1 after an edge and returns likewise
  task automatic send_line(input int row, input int off);
    for (int c = 0; c < IW; c++) begin
      int w;
      w = 0;
      while (!pix_ready && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 50) check("pix_ready_timeout", 256'(pix_ready), 256'(1));
      pix_valid = 1'b1;
      pix_in    = DW'(16*row + c + off);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  // Wait for the published set to flip; check the edge count from the call.
  task automatic wait_flip(input int exp_n, input string tag);
    logic prev;
    int n;
    prev = switch;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (switch == prev && n < 30);
    check(tag, 256'(n), 256'(exp_n));
    exp_sw = ~exp_sw;
  endtask

  task automatic check_window(input int l, input int c, input int off, input string tag);
    logic [16*DW-1:0] pub, e;
    exp_q.push_back(exp_win(l, c, off));
    e = exp_q.pop_front();
    pub = exp_sw ? win_s1 : win_s0;
    check({tag, "_switch"}, 256'(switch), 256'(exp_sw));
    check({tag, "_col"}, 256'(win_col), 256'(c));
    check({tag, "_mux_sel"}, 256'(mux_sel), 256'((l - 3) % 4));
    check({tag, "_valid"}, 256'(win_valid), 256'(1));
    check({tag, "_win"}, 256'(pub), 256'(e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s0"}, 256'(win_s0), 256'(0));
    check({tag, "_s1"}, 256'(win_s1), 256'(0));
    check({tag, "_switch"}, 256'(switch), 256'(0));
    check({tag, "_mux_sel"}, 256'(mux_sel), 256'(0));
    check({tag, "_valid"}, 256'(win_valid), 256'(0));
    check({tag, "_col"}, 256'(win_col), 256'(0));
    check({tag, "_fdone"}, 256'(frame_done), 256'(0));
    check({tag, "_ready"}, 256'(pix_ready), 256'(1));
  endtask

  task automatic run_scan(input int l, input int off, input string tag);
    for (int c = 0; c <= IW - 4; c++) begin
      wait_flip(5, $sformatf("%s_lat_c%0d", tag, c));
      check_window(l, c, off, $sformatf("%s_c%0d", tag, c));
    end
  endtask

  initial begin
    logic [16*DW-1:0] held;
    rst_n = 1'b1; pix_in = '0; pix_valid = 1'b0; win_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // first scan, ack tied high
    win_ack = 1'b1;
    for (int r = 0; r < 4; r++) send_line(r, 0);
    check("ready_drop", 256'(pix_ready), 256'(0));
    run_scan(3, 0, "scan3");
    check("ready_after_scan3", 256'(pix_ready), 256'(1));
    check("no_fdone_scan3", 256'(frame_done), 256'(0));

    // rotation: line 4 lands in bank 0
    send_line(4, 0);
    run_scan(4, 0, "scan4");

    // backpressure on the line-5 scan
    @(posedge clk); #1;
    win_ack = 1'b0;
    send_line(5, 0);
    wait_flip(5, "bp_lat_c0");
    check_window(5, 0, 0, "bp_c0");
    held = exp_sw ? win_s1 : win_s0;
    repeat (10) @(posedge clk);
    #1;
    check("bp_hold_switch", 256'(switch), 256'(exp_sw));
    check("bp_hold_col", 256'(win_col), 256'(0));
    check("bp_hold_win", 256'(exp_sw ? win_s1 : win_s0), 256'(held));
    check("bp_hold_valid", 256'(win_valid), 256'(1));
    check("bp_state_pub", 256'(dbg_state), 256'(2));
    win_ack = 1'b1;
    wait_flip(1, "bp_ack_flip");
    win_ack = 1'b0;
    check_window(5, 1, 0, "bp_c1");
    @(posedge clk); #1;
    check("bp_valid_kept", 256'(win_valid), 256'(1));
    win_ack = 1'b1;
    wait_flip(4, "bp_lat_c2");
    check_window(5, 2, 0, "bp_c2");
    for (int c = 3; c <= IW - 4; c++) begin
      wait_flip(5, $sformatf("bp_lat_c%0d", c));
      check_window(5, c, 0, $sformatf("bp_c%0d", c));
    end

    // frame wrap
    check("fdone_pulse", 256'(frame_done), 256'(1));
    check("ready_after_frame", 256'(pix_ready), 256'(1));
    @(posedge clk); #1;
    check("fdone_one_cycle", 256'(frame_done), 256'(0));
    for (int r = 0; r < 3; r++) send_line(r, 5);
    repeat (8) @(posedge clk);
    #1;
    check("wrap_no_window_switch", 256'(switch), 256'(exp_sw));
    check("wrap_no_window_valid", 256'(win_valid), 256'(0));
    check("wrap_ready", 256'(pix_ready), 256'(1));
    send_line(3, 5);
    wait_flip(5, "f2_lat_c0");
    check_window(3, 0, 5, "f2_c0");

    // reset during LOAD
    @(posedge clk); #1;
    check("midload_state", 256'(dbg_state), 256'(1));
    check("midload_ready", 256'(pix_ready), 256'(0));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midload_reset");
    #3 rst_n = 1'b1;
    exp_sw = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) send_line(r, 9);
    wait_flip(5, "post_rst_lat");
    check_window(3, 0, 9, "post_rst_c0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
